mode_key_ctrl: RTL and testbench



---
 rtl/heartbeat_pkg.sv | 20 ++
 rtl/key_debounce.sv | 46 ++++
 rtl/mode_key_ctrl.sv | 98 +++++++++
 tb/tb_mode_key_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/heartbeat_pkg.sv
// Shared constants and types for the heartbeat light front end.
// Mode codes are the values driver_selector expects on its mode_select input.
package heartbeat_pkg;

    localparam int MODE_W = 4;

    localparam logic [MODE_W-1:0] MODE_1 = 4'd1;
    localparam logic [MODE_W-1:0] MODE_2 = 4'd2;
    localparam logic [MODE_W-1:0] MODE_3 = 4'd3;
    localparam logic [MODE_W-1:0] MODE_4 = 4'd4;

    localparam int CLK_HZ = 12_000_000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } press_state_t;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus debounce counter for one active-low key.
// The output is the debounced "pressed" level (1 = pressed).
module key_debounce #(
    parameter int DEB_CYC = 240000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_pressed
);

    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_pressed;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sample_pressed;

    assign w_sample_pressed = ~r_sync2;
    assign o_pressed        = r_pressed;

    // Any sample matching the current level restarts the count, so only an
    // unbroken run of DEB_CYC differing samples flips the level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_pressed <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            if (w_sample_pressed == r_pressed) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_pressed <= w_sample_pressed;
                r_cnt     <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mode_key_ctrl.sv
// Button front end: short press steps the mode (wrapping to 1), long press
// returns to mode 1. dbg_state exposes the press FSM for checkers.
module mode_key_ctrl
    import heartbeat_pkg::*;
#(
    parameter int DEB_CYC   = 240000,
    parameter int LONG_CYC  = 12000000,
    parameter int NUM_MODES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_n,
    output logic [MODE_W-1:0] mode_select,
    output logic              mode_strobe,
    output logic [1:0]        dbg_state
);

    localparam int LONG_W = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES);

    press_state_t      r_state;
    press_state_t      w_state_nxt;
    logic [LONG_W-1:0] r_long_cnt;
    logic [LONG_W-1:0] w_long_cnt_nxt;
    logic [LONG_W-1:0] w_long_cnt_inc;
    logic [MODE_W-1:0] r_mode;
    logic [MODE_W-1:0] w_mode_nxt;
    logic              r_mode_strobe;
    logic              w_pressed;

    key_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_key_debounce (
        .clk       (clk),
        .rst       (rst),
        .i_key_n   (key_n),
        .o_pressed (w_pressed)
    );

    assign w_long_cnt_inc = r_long_cnt + 1'b1;

    // The long action fires on the edge where the counter reaches its last
    // value, i.e. LONG_CYC edges after the debounced press was registered.
    // A release seen in the same cycle wins and is treated as a short press.
    always_comb begin
        w_state_nxt    = r_state;
        w_long_cnt_nxt = r_long_cnt;
        w_mode_nxt     = r_mode;
        case (r_state)
            ST_IDLE: begin
                if (w_pressed) begin
                    w_state_nxt    = ST_PRESSED;
                    w_long_cnt_nxt = '0;
                end
            end
            ST_PRESSED: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_IDLE;
                    w_mode_nxt  = (r_mode == MODE_LAST) ? MODE_1 : r_mode + 1'b1;
                end else if (w_long_cnt_inc == LONG_LAST) begin
                    w_state_nxt    = ST_LONG_HELD;
                    w_long_cnt_nxt = w_long_cnt_inc;
                    w_mode_nxt     = MODE_1;
                end else begin
                    w_long_cnt_nxt = w_long_cnt_inc;
                end
            end
            ST_LONG_HELD: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_long_cnt    <= '0;
            r_mode        <= MODE_1;
            r_mode_strobe <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_long_cnt    <= w_long_cnt_nxt;
            r_mode        <= w_mode_nxt;
            r_mode_strobe <= (w_mode_nxt != r_mode);
        end
    end

    assign mode_select = r_mode;
    assign mode_strobe = r_mode_strobe;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_mode_key_ctrl.sv
// Directed bench for mode_key_ctrl with DEB_CYC=8, LONG_CYC=40.
`timescale 1ns/1ps
module tb_mode_key_ctrl;

    logic       clk;
    logic       rst;
    logic       key_n;
    logic [3:0] mode_select;
    logic       mode_strobe;
    logic [1:0] dbg_state;

    int checks;
    int failures;
    int cyc;
    int strobe_cnt;
    int last_strobe;

    mode_key_ctrl #(
        .DEB_CYC   (8),
        .LONG_CYC  (40),
        .NUM_MODES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .mode_select (mode_select),
        .mode_strobe (mode_strobe),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #41.667 clk = ~clk;

    // ---------------- driver ----------------
    task automatic clear_counts();
        cyc         = 0;
        strobe_cnt  = 0;
        last_strobe = -1;
    endtask

    // Drive key_n at the falling edge, then count edges and strobes sampled
    // at the following falling edge. cyc = number of rising edges seen.
    task automatic run_key(input int n, input logic lvl);
        for (int i = 0; i < n; i++) begin
            key_n = lvl;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (mode_strobe === 1'b1) begin
                strobe_cnt++;
                last_strobe = cyc;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst   = 1'b1;
        key_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (mode_select !== 4'd1) begin
            failures++;
            $display("FAIL reset_mode: got %0d expected 1", mode_select);
        end
        checks++;
        if (mode_strobe !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobe: got %0b expected 0", mode_strobe);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
        rst = 1'b0;
        clear_counts();
        run_key(100, 1'b1);
        checks++;
        if (mode_select !== 4'd1 || strobe_cnt != 0) begin
            failures++;
            $display("FAIL idle_hold: mode %0d strobes %0d expected mode 1 strobes 0", mode_select, strobe_cnt);
        end
    endtask

    task automatic test_short_press();
        logic [3:0] exp_mode;
        exp_mode = 4'd1;
        for (int i = 0; i < 4; i++) begin
            exp_mode = (exp_mode == 4'd4) ? 4'd1 : exp_mode + 4'd1;
            clear_counts();
            run_key(20, 1'b0);
            checks++;
            if (dbg_state !== 2'd1) begin
                failures++;
                $display("FAIL short_held_state[%0d]: got %0d expected 1", i, dbg_state);
            end
            run_key(30, 1'b1);
            checks++;
            if (mode_select !== exp_mode) begin
                failures++;
                $display("FAIL short_mode[%0d]: got %0d expected %0d", i, mode_select, exp_mode);
            end
            checks++;
            if (strobe_cnt != 1 || last_strobe != 31) begin
                failures++;
                $display("FAIL short_strobe[%0d]: got count %0d at %0d expected 1 at 31", i, strobe_cnt, last_strobe);
            end
        end
    endtask

    task automatic test_bouncy_press();
        clear_counts();
        for (int j = 0; j < 10; j++) run_key(3, (j % 2 == 0) ? 1'b0 : 1'b1);
        run_key(20, 1'b0);
        run_key(30, 1'b1);
        checks++;
        if (mode_select !== 4'd2) begin
            failures++;
            $display("FAIL bouncy_mode: got %0d expected 2", mode_select);
        end
        checks++;
        if (strobe_cnt != 1 || last_strobe != 61) begin
            failures++;
            $display("FAIL bouncy_strobe: got count %0d at %0d expected 1 at 61", strobe_cnt, last_strobe);
        end
    endtask

    task automatic test_debounce_boundary();
        // Bounce burst plus a 7-cycle low: never stable long enough.
        clear_counts();
        for (int j = 0; j < 10; j++) run_key(2, (j % 2 == 0) ? 1'b0 : 1'b1);
        run_key(7, 1'b0);
        run_key(30, 1'b1);
        checks++;
        if (mode_select !== 4'd2 || strobe_cnt != 0) begin
            failures++;
            $display("FAIL burst_no_change: mode %0d strobes %0d expected mode 2 strobes 0", mode_select, strobe_cnt);
        end
        // Exactly 8 low cycles is the shortest accepted press.
        clear_counts();
        run_key(8, 1'b0);
        run_key(30, 1'b1);
        checks++;
        if (mode_select !== 4'd3 || strobe_cnt != 1 || last_strobe != 19) begin
            failures++;
            $display("FAIL min_press: mode %0d strobes %0d at %0d expected mode 3, 1 strobe at 19", mode_select, strobe_cnt, last_strobe);
        end
    endtask

    task automatic test_long_press();
        clear_counts();
        run_key(60, 1'b0);
        checks++;
        if (mode_select !== 4'd1) begin
            failures++;
            $display("FAIL long_mode: got %0d expected 1", mode_select);
        end
        checks++;
        if (strobe_cnt != 1 || last_strobe != 50) begin
            failures++;
            $display("FAIL long_strobe: got count %0d at %0d expected 1 at 50", strobe_cnt, last_strobe);
        end
        checks++;
        if (dbg_state !== 2'd2) begin
            failures++;
            $display("FAIL long_state: got %0d expected 2", dbg_state);
        end
        run_key(30, 1'b1);
        checks++;
        if (mode_select !== 4'd1 || strobe_cnt != 1 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL long_release: mode %0d strobes %0d state %0d expected 1,1,0", mode_select, strobe_cnt, dbg_state);
        end
        // Long press while already in mode 1: no strobe.
        clear_counts();
        run_key(60, 1'b0);
        checks++;
        if (dbg_state !== 2'd2) begin
            failures++;
            $display("FAIL long_m1_state: got %0d expected 2", dbg_state);
        end
        run_key(30, 1'b1);
        checks++;
        if (mode_select !== 4'd1 || strobe_cnt != 0) begin
            failures++;
            $display("FAIL long_m1: mode %0d strobes %0d expected mode 1 strobes 0", mode_select, strobe_cnt);
        end
    endtask

    task automatic test_reset_mid_press();
        clear_counts();
        run_key(20, 1'b0);
        run_key(30, 1'b1);
        checks++;
        if (mode_select !== 4'd2) begin
            failures++;
            $display("FAIL pre_reset_mode: got %0d expected 2", mode_select);
        end
        clear_counts();
        run_key(20, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (mode_select !== 4'd1 || mode_strobe !== 1'b0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL mid_reset: mode %0d strobe %0b state %0d expected 1,0,0", mode_select, mode_strobe, dbg_state);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_counts();
        run_key(15, 1'b0);
        run_key(30, 1'b1);
        checks++;
        if (mode_select !== 4'd2 || strobe_cnt != 1 || last_strobe != 26) begin
            failures++;
            $display("FAIL post_reset_press: mode %0d strobes %0d at %0d expected mode 2, 1 strobe at 26", mode_select, strobe_cnt, last_strobe);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks   = 0;
        failures = 0;
        clear_counts();
        test_reset();
        test_short_press();
        test_bouncy_press();
        test_debounce_boundary();
        test_long_press();
        test_reset_mid_press();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
